// File: rtl/pong_pkg.sv
// Shared screen geometry, ball FSM states and direction encodings for the pong datapath.
package pong_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [1:0] {
        SERVE  = 2'd0,
        PLAY   = 2'd1,
        SCORED = 2'd2
    } ball_state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;

endpackage

// File: rtl/pong_ball_paddle_overlap.sv
// Vertical-overlap test between the ball and one paddle; purely combinational.
module paddle_overlap #(
    parameter int SIZE = 8
) (
    input  logic [8:0] ball_y,
    input  logic [8:0] paddle_y,
    input  logic [8:0] length,
    output logic       overlap
);

    logic [10:0] ball_bot;
    logic [10:0] pad_bot;

    // Widened so ball_y+SIZE and paddle_y+length never wrap.
    assign ball_bot = 11'(ball_y) + 11'(SIZE);
    assign pad_bot  = 11'(paddle_y) + 11'(length);
    assign overlap  = (ball_bot > 11'(paddle_y)) && (11'(ball_y) < pad_bot);

endmodule

// File: rtl/pong_ball.sv
// Ball motion engine: serve/play/scored FSM, wall and paddle bounces, miss detection.
module pong_ball
    import pong_pkg::*;
#(
    parameter int SIZE       = 8,
    parameter int SPEED      = 2,
    parameter int HOLD_TICKS = 60
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       serve,
    input  logic [5:0] width,
    input  logic [8:0] length,
    input  logic [9:0] left_x,
    input  logic [9:0] right_x,
    input  logic [8:0] left_y,
    input  logic [8:0] right_y,
    output logic [9:0] ball_x,
    output logic [8:0] ball_y,
    output logic       hit,
    output logic       score_left,
    output logic       score_right,
    output logic [1:0] state
);

    localparam int          HOLD_W    = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [9:0]  X_CTR = 10'((SCREEN_W - SIZE) / 2);
    localparam logic [8:0]  Y_CTR = 9'((SCREEN_H - SIZE) / 2);
    localparam logic [9:0]  X_MAX = 10'(SCREEN_W - SIZE);
    localparam logic [8:0]  Y_MAX = 9'(SCREEN_H - SIZE);
    localparam logic [10:0] SP    = 11'(SPEED);
    localparam logic [10:0] SZ    = 11'(SIZE);

    ball_state_t       state_q, state_d;
    logic [9:0]        x_q, x_d;
    logic [8:0]        y_q, y_d;
    logic              dx_q, dx_d;
    logic              dy_q, dy_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              hit_q, hit_d;
    logic              sl_q, sl_d;
    logic              sr_q, sr_d;

    logic [10:0] x11, nx_add, nx_sub, left_edge;
    logic        x_under;
    logic [8:0]  ny_add, ny_sub;
    logic        y_under;
    logic        ov_left, ov_right;
    logic        left_hit, right_hit, left_miss, right_miss;

    paddle_overlap #(.SIZE(SIZE)) u_left_overlap (
        .ball_y   (y_q),
        .paddle_y (left_y),
        .length   (length),
        .overlap  (ov_left)
    );

    paddle_overlap #(.SIZE(SIZE)) u_right_overlap (
        .ball_y   (y_q),
        .paddle_y (right_y),
        .length   (length),
        .overlap  (ov_right)
    );

    assign x11       = {1'b0, x_q};
    assign nx_add    = x11 + SP;
    assign nx_sub    = x11 - SP;
    assign x_under   = x11 < SP;
    assign left_edge = 11'(left_x) + 11'(width);
    assign ny_add    = y_q + 9'(SPEED);
    assign ny_sub    = y_q - 9'(SPEED);
    assign y_under   = y_q < 9'(SPEED);

    assign left_hit   = (dx_q == DIR_LEFT) && (x_under || (nx_sub <= left_edge)) && ov_left;
    assign right_hit  = (dx_q == DIR_RIGHT) && ((nx_add + SZ) >= 11'(right_x)) && ov_right;
    assign left_miss  = (dx_q == DIR_LEFT) && x_under && !left_hit;
    assign right_miss = (dx_q == DIR_RIGHT) && ((x11 + SZ + SP) > 11'(SCREEN_W)) && !right_hit;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        hold_d  = hold_q;
        hit_d   = 1'b0;
        sl_d    = 1'b0;
        sr_d    = 1'b0;
        case (state_q)
            PLAY: begin
                if (tick) begin
                    if (dy_q == DIR_UP) begin
                        if (y_under) begin
                            y_d  = '0;
                            dy_d = DIR_DOWN;
                        end else begin
                            y_d = ny_sub;
                        end
                    end else if ((11'(y_q) + SZ + SP) > 11'(SCREEN_H)) begin
                        y_d  = Y_MAX;
                        dy_d = DIR_UP;
                    end else begin
                        y_d = ny_add;
                    end

                    if (left_hit) begin
                        x_d   = left_edge[9:0];
                        dx_d  = DIR_RIGHT;
                        hit_d = 1'b1;
                    end else if (right_hit) begin
                        x_d   = right_x - 10'(SIZE);
                        dx_d  = DIR_LEFT;
                        hit_d = 1'b1;
                    end else if (left_miss) begin
                        x_d     = '0;
                        sr_d    = 1'b1;
                        state_d = SCORED;
                    end else if (right_miss) begin
                        x_d     = X_MAX;
                        sl_d    = 1'b1;
                        state_d = SCORED;
                    end else begin
                        x_d = (dx_q == DIR_RIGHT) ? nx_add[9:0] : nx_sub[9:0];
                    end
                end
            end
            SCORED: begin
                if (tick) begin
                    if (hold_q == HOLD_LAST) begin
                        // dx is untouched by a miss, so it already points at the player scored on.
                        hold_d  = '0;
                        x_d     = X_CTR;
                        y_d     = Y_CTR;
                        dy_d    = DIR_DOWN;
                        state_d = SERVE;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end
            default: begin
                state_d = serve ? PLAY : SERVE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SERVE;
            x_q     <= X_CTR;
            y_q     <= Y_CTR;
            dx_q    <= DIR_RIGHT;
            dy_q    <= DIR_DOWN;
            hold_q  <= '0;
            hit_q   <= 1'b0;
            sl_q    <= 1'b0;
            sr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            hold_q  <= hold_d;
            hit_q   <= hit_d;
            sl_q    <= sl_d;
            sr_q    <= sr_d;
        end
    end

    assign ball_x      = x_q;
    assign ball_y      = y_q;
    assign hit         = hit_q;
    assign score_left  = sl_q;
    assign score_right = sr_q;
    assign state       = state_q;

endmodule

// File: tb/tb_pong_ball.sv
// Directed bench for pong_ball: a table of rally checkpoints plus reset sequences.
module tb_pong_ball;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       tick;
    logic       serve;
    logic [5:0] width;
    logic [8:0] length;
    logic [9:0] left_x, right_x;
    logic [8:0] left_y, right_y;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic       hit, score_left, score_right;
    logic [1:0] state;

    pong_ball dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tick        (tick),
        .serve       (serve),
        .width       (width),
        .length      (length),
        .left_x      (left_x),
        .right_x     (right_x),
        .left_y      (left_y),
        .right_y     (right_y),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .hit         (hit),
        .score_left  (score_left),
        .score_right (score_right),
        .state       (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit srv;
        int n;
        int ly;
        int ry;
        int ex;
        int ey;
        int est;
        int eh;
        int esl;
        int esr;
        int span_hits;
        int span_scores;
    } vec_t;

    vec_t vecs[$];
    int   total  = 0;
    int   passed = 0;
    int   stuck  = 0;
    int   span_hits, span_scores;
    logic last_hit, last_sl, last_sr;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic add(input bit srv, input int n, input int ly, input int ry,
                       input int ex, input int ey, input int est,
                       input int eh, input int esl, input int esr,
                       input int sh, input int ss);
        vec_t v;
        v.srv = srv; v.n = n; v.ly = ly; v.ry = ry;
        v.ex = ex; v.ey = ey; v.est = est;
        v.eh = eh; v.esl = esl; v.esr = esr;
        v.span_hits = sh; v.span_scores = ss;
        vecs.push_back(v);
    endtask

    // Called at posedge+1; leaves at posedge+1 with tick low again.
    task automatic do_tick();
        tick = 1'b1;
        @(posedge clk); #1;
        last_hit = hit; last_sl = score_left; last_sr = score_right;
        span_hits   += int'(hit);
        span_scores += int'(score_left) + int'(score_right);
        tick = 1'b0;
        @(posedge clk); #1;
        if (hit || score_left || score_right) stuck++;
    endtask

    task automatic do_serve();
        serve = 1'b1;
        @(posedge clk); #1;
        serve = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; tick = 1'b0; serve = 1'b0;
        width = 6'd10; length = 9'd64;
        left_x = 10'd0; right_x = 10'd600;
        left_y = 9'd100; right_y = 9'd400;

        // srv, n, ly, ry, x, y, state, hit, sl, sr, span hits, span scores
        add(0, 10, 100, 400, 316, 236, 0, 0, 0, 0, 0, 0);
        add(1,  0, 100, 400, 316, 236, 1, 0, 0, 0, 0, 0);
        add(0,  2, 100, 400, 320, 240, 1, 0, 0, 0, 0, 0);
        add(0, 135, 100, 400, 590, 436, 1, 0, 0, 0, 0, 0);
        add(0,  1, 100, 400, 592, 434, 1, 1, 0, 0, 1, 0);
        add(0, 217, 100, 400, 158,   0, 1, 0, 0, 0, 0, 0);
        add(0,  1, 100, 400, 156,   0, 1, 0, 0, 0, 0, 0);
        add(0,  1, 100, 400, 154,   2, 1, 0, 0, 0, 0, 0);
        add(0, 71, 100, 400,  12, 144, 1, 0, 0, 0, 0, 0);
        add(0,  1, 100, 400,  10, 146, 1, 1, 0, 0, 1, 0);
        add(0, 290, 296, 200, 590, 220, 1, 0, 0, 0, 0, 0);
        add(0,  1, 296, 200, 592, 218, 1, 1, 0, 0, 1, 0);
        add(0, 110, 296, 200, 372,   0, 1, 0, 0, 0, 0, 0);
        add(0,  1, 296, 200, 370,   2, 1, 0, 0, 0, 0, 0);
        add(0, 180, 296, 200,  10, 362, 1, 0, 0, 0, 0, 0);
        add(0,  5, 296, 200,   0, 372, 1, 0, 0, 0, 0, 0);
        add(0,  1, 296, 200,   0, 374, 2, 0, 0, 1, 0, 1);
        add(1, 59, 296, 200,   0, 374, 2, 0, 0, 0, 0, 0);
        add(0,  1, 296, 200, 316, 236, 0, 0, 0, 0, 0, 0);
        add(1,  1, 296, 200, 314, 238, 1, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_x", int'(ball_x), 316);
        chk("rst_y", int'(ball_y), 236);
        chk("rst_state", int'(state), 0);
        chk("rst_pulses", int'({hit, score_left, score_right}), 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            left_y  = 9'(vecs[i].ly);
            right_y = 9'(vecs[i].ry);
            span_hits = 0; span_scores = 0;
            if (vecs[i].srv) do_serve();
            last_hit = hit; last_sl = score_left; last_sr = score_right;
            for (int k = 0; k < vecs[i].n; k++) do_tick();
            chk($sformatf("r%0d_x", i), int'(ball_x), vecs[i].ex);
            chk($sformatf("r%0d_y", i), int'(ball_y), vecs[i].ey);
            chk($sformatf("r%0d_state", i), int'(state), vecs[i].est);
            chk($sformatf("r%0d_hit", i), int'(last_hit), vecs[i].eh);
            chk($sformatf("r%0d_score_left", i), int'(last_sl), vecs[i].esl);
            chk($sformatf("r%0d_score_right", i), int'(last_sr), vecs[i].esr);
            chk($sformatf("r%0d_span_hits", i), span_hits, vecs[i].span_hits);
            chk($sformatf("r%0d_span_scores", i), span_scores, vecs[i].span_scores);
        end
        chk("pulse_width", stuck, 0);

        // Asynchronous reset in the middle of a PLAY cycle.
        do_tick();
        chk("pre_rst_x", int'(ball_x), 312);
        chk("pre_rst_y", int'(ball_y), 240);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_x", int'(ball_x), 316);
        chk("async_rst_y", int'(ball_y), 236);
        chk("async_rst_state", int'(state), 0);
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        reset_n = 1'b1;
        do_tick();
        do_tick();
        chk("post_rst_state", int'(state), 0);
        chk("post_rst_x", int'(ball_x), 316);
        chk("post_rst_y", int'(ball_y), 236);

        // After reset the serve direction is right/down again.
        do_serve();
        do_tick();
        chk("reserve_x", int'(ball_x), 318);
        chk("reserve_y", int'(ball_y), 238);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pong_ball.md
# pong_ball

Ball motion engine for the pong datapath. Owns the ball's upper-left X/Y coordinates and direction, and advances them once per frame tick. Bounces the ball off the top/bottom walls and both paddles, and detects misses to generate scoring pulses. It consumes the paddle blocks' coordinate outputs and feeds its own coordinates back to them and to the renderer.

## Interface
- SIZE, 8: ball edge length in pixels (square ball).
- SPEED, 2: pixels moved per tick on each axis (1–15).
- HOLD_TICKS, 60: ticks spent in SCORED before returning to SERVE.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle frame-rate enable; all motion happens only on tick cycles.
- serve  in  1  level/pulse; launches the ball from SERVE.
- width  in  6  paddle width, shared by both paddles (0–63).
- length  in  9  paddle length, shared by both paddles.
- left_x, right_x  in  10 each  paddle upper-left X.
- left_y, right_y  in  9 each  paddle upper-left Y.
- ball_x  out  10  ball upper-left X.
- ball_y  out  9  ball upper-left Y.
- hit  out  1  one-cycle pulse on any paddle bounce.
- score_left, score_right  out  1 each  one-cycle pulse; the named player scored.
- state  out  2  current FSM state (debug/LED).

## Operation
- States: SERVE=0, PLAY=1, SCORED=2; 3 is unused and decodes to SERVE.
- Reset values: state SERVE, ball_x=(640−SIZE)/2=316, ball_y=(480−SIZE)/2=236, dx=right, dy=down, hit/score pulses 0, hold counter 0.
- SERVE: ball held at center. serve=1 moves to PLAY on the next clock, regardless of tick. Motion begins at the first tick after entry.
- PLAY, on tick: compute candidate nx = x±SPEED and ny = y±SPEED in 11-bit unsigned with underflow detection. Then, in order:
  - Y axis: moving up with y<SPEED → y=0, dy=down. Moving down with y+SIZE+SPEED>480 → y=480−SIZE, dy=up. Otherwise y=ny.
  - Left paddle: moving left, nx ≤ left_x+width (or underflow), and vertical overlap (ball_y+SIZE > left_y and ball_y < left_y+length) → x=left_x+width, dx=right, hit.
  - Right paddle: moving right, nx+SIZE ≥ right_x, and overlap with right_y → x=right_x−SIZE, dx=left, hit.
  - Left miss: moving left, x<SPEED, no left hit → x=0, score_right pulse, go to SCORED.
  - Right miss: moving right, x+SIZE+SPEED>640, no right hit → x=640−SIZE, score_left pulse, go to SCORED.
  - Otherwise x=nx.
- Overlap uses current (pre-move) ball_y. The X and Y updates apply in the same tick, so corner bounces flip both directions.
- SCORED: ball frozen. Hold counter increments per tick. When it reaches HOLD_TICKS−1 on a tick: counter clears, ball is re-centered, dx points toward the player who was scored on, dy=down, and the FSM goes to SERVE.
- serve is ignored outside SERVE; tick is ignored in SERVE.
- Paddle inputs are sampled only on PLAY ticks; there is no requirement on their stability otherwise.

## Timing
- All outputs are registered. Position, state and pulses change on the clock edge of the tick cycle, i.e. visible one cycle after tick is asserted.
- hit, score_left and score_right are high for exactly one clk cycle.
- reset_n low forces all outputs to reset values immediately (asynchronously), including mid-PLAY and mid-SCORED. Release is synchronous to the next edge.

## Structure
- Shared package pong_pkg holds:
  - SCREEN_W=640 and SCREEN_H=480;
  - the ball state enum (SERVE/PLAY/SCORED);
  - direction constants (DIR_LEFT/DIR_RIGHT, DIR_UP/DIR_DOWN).
- One combinational sub-module, paddle_overlap, instantiated twice. Inputs are ball_y, SIZE, paddle_y and length; output is the vertical-overlap flag.
- FSM, position registers and hold counter live in pong_ball.

## Test plan
- Reset, then 10 ticks without serve → ball_x=316, ball_y=236, state=0 throughout, no pulses.
- serve pulse, then one tick → state=1, ball (318,238). Second tick → (320,240).
- Top wall: ball at y=1 moving up, tick → y=0 and dy=down. Next tick → y=2.
- Left bounce: left paddle (0,200), width=10, length=64; ball at x=11, y=220 moving left; tick → x=10, dx=right, hit=1 for one cycle.
- Left miss: left paddle at y=300; ball at x=1, y=100 moving left; tick → x=0, score_right=1 for one cycle, state=2. After 60 further ticks → state=0, ball (316,236), dx=left. 59 ticks → still state 2.
- Assert reset_n low mid-PLAY between clock edges → outputs return to reset values without a clock edge. Release → stays SERVE.
